// File: rtl/mux2_arbiter_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : mux2_arb_pkg
// Description : Shared definitions for the two-requester packet arbiter.
//               FSM state encoding, watchdog counter width, requester
//               index constants and a helper that maps an index to its
//               grant state.
// Revision    : 1.0 - initial release
// ============================================================================
package mux2_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

    localparam int   HOLD_CNT_W = 16;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    // Grant state that corresponds to a requester index.
    function automatic arb_state_t gnt_state(input logic idx);
        return (idx == REQ1) ? GNT1 : GNT0;
    endfunction

endpackage : mux2_arb_pkg
`default_nettype wire

// File: rtl/mux2_w.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : mux2_w
// Description : WIDTH-bit 2:1 multiplexer (purely combinational).
// Ports       : sel  - 0 selects in0, 1 selects in1
//               in0  - input 0, WIDTH bits
//               in1  - input 1, WIDTH bits
//               out  - selected value, WIDTH bits
// Revision    : 1.0 - initial release
// ============================================================================
module mux2_w #(
    parameter int WIDTH = 8
) (
    input  logic             sel,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    output logic [WIDTH-1:0] out
);

    assign out = sel ? in1 : in0;

endmodule : mux2_w
`default_nettype wire

// File: rtl/mux2_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : mux2_arbiter
// Description : Packet-aware round-robin arbiter sharing one valid/ready
//               channel between two requesters. A grant is held for a whole
//               packet (through the last beat). Valid, data, last and ready
//               pass combinationally through the registered select.
// Ports       : clk, rst_n (async, active low)
//               req0_valid/last/data/ready, req1_valid/last/data/ready
//               out_valid/last/data, out_ready
//               sel         - registered datapath select (0=req0, 1=req1)
//               busy        - a grant is held
//               timeout_err - one-cycle pulse on watchdog release
// Config      : ARB_HOLD_LIMIT_EN - when defined, a stall watchdog releases
//               a grant after HOLD_MAX cycles without a valid beat.
//               Otherwise timeout_err is tied low and grants never expire.
// Revision    : 1.0 - initial release
// ============================================================================
module mux2_arbiter
    import mux2_arb_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int HOLD_MAX = 16
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    input  logic             req0_last,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,

    input  logic             req1_valid,
    input  logic             req1_last,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,

    output logic             out_valid,
    output logic             out_last,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,

    output logic             sel,
    output logic             busy,
    output logic             timeout_err
);

    // Reject out-of-range watchdog limits at elaboration.
    if ((HOLD_MAX < 2) || (HOLD_MAX > ((1 << HOLD_CNT_W) - 1))) begin : g_hold_max_chk
        $error("mux2_arbiter: HOLD_MAX out of range 2..65535");
    end

    arb_state_t r_state;
    arb_state_t w_state_nxt;
    logic       r_sel;
    logic       w_sel_nxt;
    logic       r_last_gnt;
    logic       w_last_gnt_nxt;

    logic       w_granted;
    logic       w_mux_valid;
    logic       w_mux_last;
    logic       w_oth_valid;
    logic       w_beat_acc;
    logic       w_pkt_end;
    logic       w_wd_fire;

    // ------------------------------------------------------------------
    // Shared datapath. r_sel always equals the granted index while a grant
    // is held, so the same select serves both the granted and IDLE cases.
    // ------------------------------------------------------------------
    mux2_w #(.WIDTH(WIDTH)) u_mux_data (
        .sel (r_sel),
        .in0 (req0_data),
        .in1 (req1_data),
        .out (out_data)
    );

    mux2_w #(.WIDTH(1)) u_mux_last (
        .sel (r_sel),
        .in0 (req0_last),
        .in1 (req1_last),
        .out (w_mux_last)
    );

    mux2_w #(.WIDTH(1)) u_mux_valid (
        .sel (r_sel),
        .in0 (req0_valid),
        .in1 (req1_valid),
        .out (w_mux_valid)
    );

    assign w_granted   = (r_state != IDLE);
    assign w_oth_valid = r_sel ? req0_valid : req1_valid;
    assign w_beat_acc  = w_granted & w_mux_valid & out_ready;
    assign w_pkt_end   = w_beat_acc & w_mux_last;

    assign out_valid   = w_granted & w_mux_valid;
    assign out_last    = w_mux_last;
    assign req0_ready  = (r_state == GNT0) & out_ready;
    assign req1_ready  = (r_state == GNT1) & out_ready;
    assign sel         = r_sel;
    assign busy        = w_granted;

    // ------------------------------------------------------------------
    // Stall watchdog
    // ------------------------------------------------------------------
`ifdef ARB_HOLD_LIMIT_EN
    localparam logic [HOLD_CNT_W-1:0] c_hold_max = HOLD_CNT_W'(HOLD_MAX);

    logic [HOLD_CNT_W-1:0] r_hold_cnt;
    logic [HOLD_CNT_W-1:0] w_hold_inc;
    logic                  r_timeout_err;

    assign w_hold_inc = r_hold_cnt + HOLD_CNT_W'(1);
    // Fires on the stall cycle that would bring the count to HOLD_MAX.
    assign w_wd_fire  = w_granted & ~w_mux_valid & (w_hold_inc == c_hold_max);

    // IDLE keeps the counter at zero, so every grant entry starts fresh;
    // a direct grant hand-over always coincides with an accepted beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_cnt    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= w_wd_fire;
            if (!w_granted || w_beat_acc || w_wd_fire) begin
                r_hold_cnt <= '0;
            end else if (!w_mux_valid) begin
                r_hold_cnt <= w_hold_inc;
            end
        end
    end

    assign timeout_err = r_timeout_err;
`else
    assign w_wd_fire   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Grant FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_sel      <= REQ0;
            r_last_gnt <= REQ1;     // req0 wins the first tie
        end else begin
            r_state    <= w_state_nxt;
            r_sel      <= w_sel_nxt;
            r_last_gnt <= w_last_gnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_sel_nxt      = r_sel;
        w_last_gnt_nxt = r_last_gnt;
        case (r_state)
            IDLE: begin
                if (req0_valid && req1_valid) begin
                    w_state_nxt = gnt_state(~r_last_gnt);
                    w_sel_nxt   = ~r_last_gnt;
                end else if (req0_valid) begin
                    w_state_nxt = GNT0;
                    w_sel_nxt   = REQ0;
                end else if (req1_valid) begin
                    w_state_nxt = GNT1;
                    w_sel_nxt   = REQ1;
                end
            end
            GNT0, GNT1: begin
                if (w_pkt_end) begin
                    w_last_gnt_nxt = r_sel;
                    // Hand straight over to a waiting peer; a repeating
                    // requester goes back through IDLE instead.
                    if (w_oth_valid) begin
                        w_state_nxt = gnt_state(~r_sel);
                        w_sel_nxt   = ~r_sel;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else if (w_wd_fire) begin
                    w_last_gnt_nxt = r_sel;
                    w_state_nxt    = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

endmodule : mux2_arbiter
`default_nettype wire

// File: doc/mux2_arbiter.md
# mux2_arbiter

Two-requester, packet-aware round-robin arbiter that shares one WIDTH-bit output channel between two valid/ready sources. It owns the 2:1 select of the shared datapath and grants a whole packet (up to and including the `last` beat) before switching. It sits directly in front of the shared channel and is its only driver.

## Interface

**Parameters**
- `WIDTH`, default 8: data width of each requester and of the output channel.
- `HOLD_MAX`, default 16: stall-watchdog limit in cycles. Used only when `ARB_HOLD_LIMIT_EN` is defined. Legal range is 2..65535.

**Ports**
- `clk`, in, 1: single clock. All state updates on the rising edge.
- `rst_n`, in, 1: asynchronous active-low reset. Asserts immediately; deasserts synchronously to `clk` at the SoC level.
- `req0_valid`, `req0_last`, in, 1 each: requester 0 beat valid and end-of-packet.
- `req0_data`, in, WIDTH: requester 0 data.
- `req0_ready`, out, 1: beat accepted from requester 0.
- `req1_valid`, `req1_last`, `req1_data`, `req1_ready`: same as requester 0, for requester 1.
- `out_valid`, `out_last`, out, 1 each: shared channel beat valid and end-of-packet.
- `out_data`, out, WIDTH: shared channel data.
- `out_ready`, in, 1: downstream accepts the beat.
- `sel`, out, 1: current datapath select (0 = req0, 1 = req1). Registered.
- `busy`, out, 1: high while a grant is held.
- `timeout_err`, out, 1: one-cycle pulse on watchdog release. Tied 0 when the feature is compiled out.

## Operation

- **States:** IDLE, GNT0, GNT1. State is 2 bits, registered.
- **IDLE:**
  - Only one valid: go to the matching GNTx.
  - Both valid: grant the requester that is not `last_gnt`.
  - None valid: stay in IDLE.
- **GNTx:**
  - `out_valid = reqx_valid`, `out_data = reqx_data`, `out_last = reqx_last`.
  - `reqx_ready = out_ready`. The non-granted requester's ready is 0.
- **Packet end:** on `out_valid & out_ready & out_last`, update `last_gnt` to x.
  - If the other requester is valid in the same cycle, go directly to its GNT state (no bubble).
  - Otherwise go to IDLE, including when the same requester still has data. That requester re-arbitrates from IDLE.
- **No pre-emption:** a grant never switches mid-packet, except through the watchdog.
- **In IDLE:** `out_valid = 0`, both readies 0, `out_data` = `req0_data` when `sel = 0`, otherwise `req1_data`.
- **`sel`:** equals the granted index while in GNTx. It holds its last value in IDLE.
- **Reset values:** state IDLE, `sel = 0`, `last_gnt = 1` (req0 wins the first tie), `busy = 0`, `timeout_err = 0`. All readies and `out_valid` are 0.
- **Mid-packet reset:** the packet is dropped with no flush. The first transaction after reset follows the IDLE rules.

## Timing

- **Arbitration latency:** one cycle. A request seen in IDLE at edge n produces `out_valid` in cycle n+1.
- **Throughput:** one beat per cycle within a packet. Back-to-back packets from alternating requesters have zero bubbles; a requester that repeats itself costs one IDLE cycle.
- **Combinational paths:** valid, data, last, and ready pass through combinationally from the grant (no registers on the data path). `out_ready` to `reqx_ready` is a combinational path.
- **Simultaneous events:** when a last beat and the other requester's valid coincide, the next-state decision uses that cycle's valid.

## Configuration

- **`ARB_HOLD_LIMIT_EN` defined:**
  - A 16-bit counter clears on every accepted beat and on grant entry.
  - It increments each GNTx cycle in which `reqx_valid = 0`.
  - When the count reaches `HOLD_MAX`, the grant is forced to IDLE and `timeout_err` pulses for one cycle. `last_gnt` is updated to x, and the other requester wins the next arbitration.
- **`ARB_HOLD_LIMIT_EN` undefined:** there is no counter, grants are held indefinitely, and `timeout_err` is constant 0.

## Structure

- **Package `mux2_arb_pkg`:** the state encoding (IDLE = 0, GNT0 = 1, GNT1 = 2), the `HOLD_CNT_W = 16` constant, and index constants REQ0 = 0 and REQ1 = 1.
- **Sub-module `mux2_w`:** a WIDTH-parameterised 2:1 mux, instantiated for data and, at width 1, for last and valid.
- **Arbiter top:** holds the FSM, `last_gnt`, the watchdog counter, and the ready steering.

## Test plan

- **Single requester:** req0 sends 3 beats (0x11, 0x22, 0x33 with last) and `out_ready = 1`. Expect `out_data` 0x11/0x22/0x33 in cycles 1–3, `sel = 0`, and return to IDLE in cycle 4.
- **Tie after reset:** both requesters valid in the first cycle. Expect req0 granted first. The req1 packet follows with zero bubble and `sel` going 0→1.
- **Fairness:** both requesters send continuous 2-beat packets. Expect strictly alternating grants over 8 packets and `req1_ready = 0` throughout every req0 packet.
- **Backpressure:** `out_ready` is low for 4 cycles mid-packet. Expect the beat held stable, the granted ready low, no grant switch, and the packet completing intact.
- **Watchdog (macro on, `HOLD_MAX = 4`):** req0 drops valid mid-packet while req1 is waiting. Expect `timeout_err` for one cycle after 4 stall cycles, then req1 granted the next cycle. With the macro off, the grant is held indefinitely.
- **Reset mid-packet:** pulse `rst_n` low during GNT1. Expect all outputs at their reset values immediately, and the next tie granted to req0.
